// File: rtl/adder_accumulator_ctrl.sv
// Operand/accumulator registers and sequencing FSM around an external combinational adder.
// Optional ACC_SATURATE_EN clamps the accumulator to all ones on carry-out instead of wrapping.
module adder_accumulator_ctrl #(
  parameter int WIDTH         = 16,
  parameter int SETTLE_CYCLES = 2
) (
  input  logic             Clk,
  input  logic             Reset,
  input  logic [WIDTH-1:0] SW,
  input  logic             Run,
  input  logic             ClearA_LoadB,
  input  logic [WIDTH-1:0] Adder_Sum,
  input  logic             Adder_CO,
  output logic [WIDTH-1:0] Adder_A,
  output logic [WIDTH-1:0] Adder_B,
  output logic [WIDTH-1:0] Acc,
  output logic             CO_out,
  output logic             Busy,
  output logic             Done
);

  typedef enum logic [1:0] {IDLE, SETTLE, CAPTURE, HOLD} state_t;

  localparam logic [3:0] CNT_INIT = 4'(SETTLE_CYCLES - 1);

  state_t           state_q, state_d;
  logic [3:0]       cnt_q, cnt_d;
  logic [WIDTH-1:0] acc_q, acc_d;
  logic [WIDTH-1:0] b_q, b_d;
  logic             co_q, co_d;
  logic             done_q, done_d;

  always_ff @(posedge Clk) begin
    if (Reset) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      acc_q   <= '0;
      b_q     <= '0;
      co_q    <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      acc_q   <= acc_d;
      b_q     <= b_d;
      co_q    <= co_d;
      done_q  <= done_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    acc_d   = acc_q;
    b_d     = b_q;
    co_d    = co_q;
    done_d  = 1'b0;
    unique case (state_q)
      IDLE: begin
        // Clear/load has priority; a concurrent Run is picked up next cycle.
        if (ClearA_LoadB) begin
          acc_d = '0;
          b_d   = SW;
          co_d  = 1'b0;
        end else if (Run) begin
          cnt_d   = CNT_INIT;
          state_d = SETTLE;
        end
      end
      SETTLE: begin
        if (cnt_q == 4'd0) state_d = CAPTURE;
        else               cnt_d   = cnt_q - 4'd1;
      end
      CAPTURE: begin
`ifdef ACC_SATURATE_EN
        acc_d = Adder_CO ? '1 : Adder_Sum;
`else
        acc_d = Adder_Sum;
`endif
        co_d    = Adder_CO;
        done_d  = 1'b1;
        state_d = HOLD;
      end
      HOLD: begin
        if (!Run) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  assign Adder_A = acc_q;
  assign Acc     = acc_q;
  assign Adder_B = b_q;
  assign CO_out  = co_q;
  assign Done    = done_q;
  assign Busy    = (state_q != IDLE);

endmodule

// File: tb/tb_adder_accumulator_ctrl.sv
// Directed + randomized check of adder_accumulator_ctrl against an arithmetic accumulate model.
module tb_adder_accumulator_ctrl;

  localparam int W = 16;
  localparam int S = 2;

  logic         Clk = 1'b0;
  logic         Reset, Run, ClearA_LoadB;
  logic [W-1:0] SW;
  logic [W-1:0] Adder_Sum, Adder_A, Adder_B, Acc;
  logic         Adder_CO, CO_out, Busy, Done;

  int n_cmp = 0;
  int n_bad = 0;

  logic [W-1:0] m_acc, m_b;
  logic         m_co;

  adder_accumulator_ctrl #(.WIDTH(W), .SETTLE_CYCLES(S)) dut (
    .Clk(Clk), .Reset(Reset), .SW(SW), .Run(Run), .ClearA_LoadB(ClearA_LoadB),
    .Adder_Sum(Adder_Sum), .Adder_CO(Adder_CO), .Adder_A(Adder_A), .Adder_B(Adder_B),
    .Acc(Acc), .CO_out(CO_out), .Busy(Busy), .Done(Done)
  );

  // External adder
  assign {Adder_CO, Adder_Sum} = {1'b0, Adder_A} + {1'b0, Adder_B};

  always #5 Clk = ~Clk;

  task automatic tick();
    @(posedge Clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic chk_idle(input string tag);
    chk({tag, "_acc"}, 32'(Acc), 32'(m_acc));
    chk({tag, "_adderA"}, 32'(Adder_A), 32'(m_acc));
    chk({tag, "_b"}, 32'(Adder_B), 32'(m_b));
    chk({tag, "_co"}, 32'(CO_out), 32'(m_co));
    chk({tag, "_busy"}, 32'(Busy), 32'd0);
    chk({tag, "_done"}, 32'(Done), 32'd0);
  endtask

  task automatic do_clear(input logic [W-1:0] sw);
    ClearA_LoadB = 1'b1;
    SW = sw;
    tick();
    ClearA_LoadB = 1'b0;
    m_acc = '0;
    m_b   = sw;
    m_co  = 1'b0;
    chk_idle("clear");
  endtask

  // One add with Run held for 'hold' cycles; optionally pokes ClearA_LoadB during HOLD.
  task automatic do_add(input int hold, input bit clr_in_hold);
    logic [W:0]   full;
    logic [W-1:0] old_acc, new_acc;
    int           e;
    full    = {1'b0, m_acc} + {1'b0, m_b};
    old_acc = m_acc;
`ifdef ACC_SATURATE_EN
    new_acc = full[W] ? '1 : full[W-1:0];
`else
    new_acc = full[W-1:0];
`endif
    e = (hold > S + 2) ? hold : S + 2;
    Run = 1'b1;
    for (int i = 0; i <= e; i++) begin
      tick();
      if (i == hold - 1) Run = 1'b0;
      chk("add_busy", 32'(Busy), 32'(i < e));
      chk("add_done", 32'(Done), 32'(i == S + 1));
      chk("add_acc", 32'(Acc), 32'((i < S + 1) ? old_acc : new_acc));
      chk("add_b", 32'(Adder_B), 32'(m_b));
      if (i >= S + 1) chk("add_co", 32'(CO_out), 32'(full[W]));
      if (clr_in_hold && i >= S + 1 && i + 1 < e) begin
        ClearA_LoadB = 1'b1;
        SW = '1;
      end else begin
        ClearA_LoadB = 1'b0;
      end
    end
    m_acc = new_acc;
    m_co  = full[W];
    chk_idle("add_end");
  endtask

  initial begin
    Reset = 1'b1; Run = 1'b0; ClearA_LoadB = 1'b0; SW = '0;
    m_acc = '0; m_b = '0; m_co = 1'b0;
    tick(); tick();
    Reset = 1'b0;
    chk_idle("reset");

    // Load B=3, then three adds -> 3, 6, 9
    do_clear(16'h0003);
    do_add(10, 1'b0);
    chk("acc_3", 32'(Acc), 32'h0003);
    do_add(1, 1'b0);
    do_add(3, 1'b0);
    chk("acc_9", 32'(Acc), 32'h0009);

    // Overflow: 0x8000 + 0x8000
    do_clear(16'h8000);
    do_add(1, 1'b0);
    do_add(2, 1'b0);
`ifdef ACC_SATURATE_EN
    chk("ovf_acc", 32'(Acc), 32'hFFFF);
`else
    chk("ovf_acc", 32'(Acc), 32'h0000);
`endif
    chk("ovf_co", 32'(CO_out), 32'd1);

    // Run and ClearA_LoadB together: clear wins, add follows
    Run = 1'b1; ClearA_LoadB = 1'b1; SW = 16'h0010;
    tick();
    ClearA_LoadB = 1'b0;
    m_acc = '0; m_b = 16'h0010; m_co = 1'b0;
    chk_idle("both");
    do_add(1, 1'b0);
    chk("both_acc", 32'(Acc), 32'h0010);

    // Reset during SETTLE
    Run = 1'b1;
    tick(); tick();
    Run = 1'b0;
    chk("rst_pre_busy", 32'(Busy), 32'd1);
    Reset = 1'b1;
    tick();
    Reset = 1'b0;
    m_acc = '0; m_b = '0; m_co = 1'b0;
    chk_idle("rst_mid");
    for (int k = 0; k < S + 3; k++) tick();
    chk_idle("rst_after");

    // ClearA_LoadB during HOLD is ignored
    do_clear(16'h1234);
    do_add(8, 1'b1);
    chk("hold_clr_b", 32'(Adder_B), 32'h1234);
    chk("hold_clr_acc", 32'(Acc), 32'h1234);

    // Randomized mix
    for (int n = 0; n < 40; n++) begin
      if ($urandom_range(0, 3) == 0) do_clear(W'($urandom));
      else do_add(int'($urandom_range(1, 7)), 1'($urandom_range(0, 1)));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
